// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

    localparam int W  = 32;
    localparam int RW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_BAD = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        CTL_ADD   = 2'b00,
        CTL_SUB   = 2'b01,
        CTL_FUNCT = 2'b10,
        CTL_ORI   = 2'b11
    } alu_ctl_t;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_t;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Contents of the single EX/MEM pipeline register.
    typedef struct packed {
        logic [W-1:0]  result;
        logic [W-1:0]  store_data;
        logic [W-1:0]  branch_target;
        logic [RW-1:0] rd;
        logic          zero;
        logic          branch_taken;
        logic          illegal;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> MEM pipeline bus with valid/ready on both sides.
// Latency: wires only.
// Backpressure: in_ready / out_ready carry the stall in each direction.
interface ex_stage_if;
    import mips_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_alu_ctl;
    logic [5:0]    in_funct;
    logic          in_alusrc;
    logic [15:0]   in_imm;
    logic [W-1:0]  in_pc4;
    logic [W-1:0]  in_rs_data;
    logic [W-1:0]  in_rt_data;
    logic [1:0]    in_fwd_a;
    logic [1:0]    in_fwd_b;
    logic [RW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_branch;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [W-1:0]  out_store_data;
    logic [W-1:0]  out_branch_target;
    logic [RW-1:0] out_rd;
    logic          out_zero;
    logic          out_branch_taken;
    logic          out_illegal;
    logic          out_reg_write;
    logic          out_mem_read;
    logic          out_mem_write;

    // Execute stage side.
    modport slave (
        input  in_valid, in_alu_ctl, in_funct, in_alusrc, in_imm, in_pc4,
               in_rs_data, in_rt_data, in_fwd_a, in_fwd_b, in_rd,
               in_reg_write, in_mem_read, in_mem_write, in_branch, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_branch_target,
               out_rd, out_zero, out_branch_taken, out_illegal,
               out_reg_write, out_mem_read, out_mem_write
    );

    // Surrounding pipeline side (ID/EX producer and memory-stage consumer).
    modport master (
        output in_valid, in_alu_ctl, in_funct, in_alusrc, in_imm, in_pc4,
               in_rs_data, in_rt_data, in_fwd_a, in_fwd_b, in_rd,
               in_reg_write, in_mem_read, in_mem_write, in_branch, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_branch_target,
               out_rd, out_zero, out_branch_taken, out_illegal,
               out_reg_write, out_mem_read, out_mem_write
    );

endinterface

// File: rtl/alu_control.sv
// Decodes ALUOp and funct into the 4-bit ALU op code plus an illegal flag.
// Latency: combinational.
// Backpressure: none.
module alu_control import mips_pkg::*; (
    input  alu_ctl_t   alu_ctl,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       illegal
);

    // Unknown R-type functs map to the BAD op, which the ALU answers with 0.
    always_comb begin
        alu_op  = ALU_BAD;
        illegal = 1'b0;
        case (alu_ctl)
            CTL_ADD: alu_op = ALU_ADD;
            CTL_SUB: alu_op = ALU_SUB;
            CTL_ORI: alu_op = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    default: begin
                        alu_op  = ALU_BAD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU op decode, single-entry EX/MEM register.
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle while out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled entry holds every out_* field.
module ex_stage import mips_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    ex_stage_if.slave     bus,
    input  logic [W-1:0]  wb_data,
    input  logic          flush,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_zero
);

    alu_op_t      dec_op;
    logic         dec_illegal;
    logic [W-1:0] fwd_a_val;
    logic [W-1:0] fwd_b_val;
    logic [W-1:0] imm_ext;
    logic [W-1:0] br_off;
    logic         accept;
    exmem_t       entry;
    exmem_t       exmem_d, exmem_q;
    logic         out_valid_d, out_valid_q;
    logic         alu_zero_unused;

    // The external zero flag is not trusted; zero is rebuilt from the result.
    assign alu_zero_unused = alu_zero;

    alu_control u_alu_control (
        .alu_ctl (alu_ctl_t'(bus.in_alu_ctl)),
        .funct   (bus.in_funct),
        .alu_op  (dec_op),
        .illegal (dec_illegal)
    );

    // Forwarding from MEM reads the EX/MEM register even when it holds no valid entry.
    always_comb begin
        fwd_a_val = bus.in_rs_data;
        fwd_b_val = bus.in_rt_data;
        case (fwd_sel_t'(bus.in_fwd_a))
            FWD_MEM: fwd_a_val = exmem_q.result;
            FWD_WB:  fwd_a_val = wb_data;
            default: fwd_a_val = bus.in_rs_data;
        endcase
        case (fwd_sel_t'(bus.in_fwd_b))
            FWD_MEM: fwd_b_val = exmem_q.result;
            FWD_WB:  fwd_b_val = wb_data;
            default: fwd_b_val = bus.in_rt_data;
        endcase
    end

    // ori zero-extends its immediate; everything else sign-extends.
    assign imm_ext = (alu_ctl_t'(bus.in_alu_ctl) == CTL_ORI) ? {16'h0000, bus.in_imm}
                                                             : {{16{bus.in_imm[15]}}, bus.in_imm};
    assign br_off  = {{14{bus.in_imm[15]}}, bus.in_imm, 2'b00};

    assign alu_a  = fwd_a_val;
    assign alu_b  = bus.in_alusrc ? imm_ext : fwd_b_val;
    assign alu_op = dec_op;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Build the candidate EX/MEM entry; illegal ops keep flowing but lose all side effects.
    always_comb begin
        entry               = '0;
        entry.result        = alu_result;
        entry.store_data    = fwd_b_val;
        entry.branch_target = bus.in_pc4 + br_off;
        entry.rd            = bus.in_rd;
        entry.zero          = (alu_result == '0);
        entry.branch_taken  = bus.in_branch && (alu_result == '0);
        entry.illegal       = dec_illegal;
        entry.reg_write     = bus.in_reg_write && !dec_illegal;
        entry.mem_read      = bus.in_mem_read  && !dec_illegal;
        entry.mem_write     = bus.in_mem_write && !dec_illegal;
    end

    // Flush beats accept beats drain; a flush keeps the data but drops the valid.
    always_comb begin
        out_valid_d = out_valid_q;
        exmem_d     = exmem_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            exmem_d     = entry;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            exmem_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            exmem_q     <= exmem_d;
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_result        = exmem_q.result;
    assign bus.out_store_data    = exmem_q.store_data;
    assign bus.out_branch_target = exmem_q.branch_target;
    assign bus.out_rd            = exmem_q.rd;
    assign bus.out_zero          = exmem_q.zero;
    assign bus.out_branch_taken  = exmem_q.branch_taken;
    assign bus.out_illegal       = exmem_q.illegal;
    assign bus.out_reg_write     = exmem_q.reg_write;
    assign bus.out_mem_read      = exmem_q.mem_read;
    assign bus.out_mem_write     = exmem_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases then randomized traffic.
// Expected entries are queued on accept and checked by a negedge monitor.
// A behavioural ALU answers alu_op; its zero flag is deliberately wrong.
module tb_ex_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        zero;
        logic        taken;
        logic        illegal;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb_q[$];
    exp_t        mon_act;
    logic [31:0] m_result;
    logic        m_valid;

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .wb_data    (wb_data),
        .flush      (flush),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // Behavioural ALU keyed on the numeric op codes.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result != 32'd0);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Op code the decoder should present for a given ALUOp/funct.
    function automatic logic [3:0] ref_code(input logic [1:0] ctl, input logic [5:0] fn);
        if (ctl == 2'b00) return 4'b0010;
        if (ctl == 2'b01) return 4'b0110;
        if (ctl == 2'b11) return 4'b0001;
        case (fn)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24:        return 4'b0000;
            6'h25:        return 4'b0001;
            6'h27:        return 4'b1100;
            6'h2A:        return 4'b0111;
            default:      return 4'b1111;
        endcase
    endfunction

    // Arithmetic meaning of the instruction, independent of op encoding.
    function automatic logic [31:0] ref_calc(input logic [1:0] ctl, input logic [5:0] fn,
                                             input logic [31:0] a, input logic [31:0] b);
        if (ctl == 2'b00) return a + b;
        if (ctl == 2'b01) return a - b;
        if (ctl == 2'b11) return a | b;
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h27:        return ~(a | b);
            6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:      return 32'd0;
        endcase
    endfunction

    // Apply one cycle of stimulus at posedge+1, check combinational outputs, queue expectations.
    task automatic drive(input logic vld, input logic [1:0] ctl, input logic [5:0] fn,
                         input logic src, input logic [15:0] imm, input logic [31:0] pc4,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] rd,
                         input logic [3:0] cb, input logic [31:0] wb, input logic fl,
                         input logic ordy);
        logic [31:0] a, b, bop, immx, res;
        logic        rdy, acc, ill;
        exp_t        e;
        bus.in_valid = vld;     bus.in_alu_ctl = ctl;  bus.in_funct = fn;
        bus.in_alusrc = src;    bus.in_imm = imm;      bus.in_pc4 = pc4;
        bus.in_rs_data = rs;    bus.in_rt_data = rt;   bus.in_fwd_a = fa;
        bus.in_fwd_b = fb;      bus.in_rd = rd;
        bus.in_reg_write = cb[3]; bus.in_mem_read = cb[2];
        bus.in_mem_write = cb[1]; bus.in_branch = cb[0];
        wb_data = wb;           flush = fl;            bus.out_ready = ordy;
        #2;
        a    = (fa == 2'b01) ? m_result : (fa == 2'b10) ? wb : rs;
        b    = (fb == 2'b01) ? m_result : (fb == 2'b10) ? wb : rt;
        immx = (ctl == 2'b11) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
        bop  = src ? immx : b;
        res  = ref_calc(ctl, fn, a, bop);
        ill  = (ref_code(ctl, fn) == 4'b1111);
        rdy  = !m_valid || ordy;
        check("alu_op", 128'(alu_op), 128'(ref_code(ctl, fn)));
        check("alu_a", 128'(alu_a), 128'(a));
        check("alu_b", 128'(alu_b), 128'(bop));
        check("in_ready", 128'(bus.in_ready), 128'(rdy));
        acc = vld && rdy;
        if (acc && !fl) begin
            e.result  = res;
            e.store   = b;
            e.target  = pc4 + {{14{imm[15]}}, imm, 2'b00};
            e.rd      = rd;
            e.zero    = (res == 32'd0);
            e.taken   = cb[0] && (res == 32'd0);
            e.illegal = ill;
            e.rw      = cb[3] && !ill;
            e.mr      = cb[2] && !ill;
            e.mw      = cb[1] && !ill;
            sb_q.push_back(e);
            m_result = res;
        end
        if (fl)                    m_valid = 1'b0;
        else if (acc)              m_valid = 1'b1;
        else if (m_valid && ordy)  m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 6'h00, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00,
              5'd0, 4'b0000, 32'h0, 1'b0, 1'b1);
    endtask

    // Monitor: every visible entry must match the queue head; it leaves on transfer or flush.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_entry: got out_result %h with nothing expected", bus.out_result);
            end else begin
                mon_act = {bus.out_result, bus.out_store_data, bus.out_branch_target, bus.out_rd,
                           bus.out_zero, bus.out_branch_taken, bus.out_illegal,
                           bus.out_reg_write, bus.out_mem_read, bus.out_mem_write};
                check("entry", 128'(mon_act), 128'(sb_q[0]));
                if (bus.out_ready || flush) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [1:0]  r_ctl;
        logic [5:0]  r_fn;
        rst_n = 1'b0;
        m_result = 32'd0;
        m_valid  = 1'b0;
        bus.in_valid = 1'b0; bus.in_alu_ctl = 2'b00; bus.in_funct = 6'h0; bus.in_alusrc = 1'b0;
        bus.in_imm = 16'h0; bus.in_pc4 = 32'h0; bus.in_rs_data = 32'h0; bus.in_rt_data = 32'h0;
        bus.in_fwd_a = 2'b00; bus.in_fwd_b = 2'b00; bus.in_rd = 5'd0; bus.in_reg_write = 1'b0;
        bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_branch = 1'b0;
        bus.out_ready = 1'b1; wb_data = 32'h0; flush = 1'b0;

        #3;
        check("reset_valid", 128'(bus.out_valid), 128'(0));
        check("reset_outs", 128'({bus.out_result, bus.out_store_data, bus.out_branch_target,
                                  bus.out_rd, bus.out_zero, bus.out_branch_taken, bus.out_illegal,
                                  bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}), 128'(0));
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type sub 5-7
        drive(1'b1, 2'b10, 6'h22, 1'b0, 16'h0, 32'h0, 32'd5, 32'd7, 2'b00, 2'b00,
              5'd3, 4'b1000, 32'h0, 1'b0, 1'b1);
        check("sub_result", 128'(bus.out_result), 128'(32'hFFFF_FFFE));
        check("sub_zero", 128'(bus.out_zero), 128'(0));

        // ori with high immediate bit: zero-extended
        drive(1'b1, 2'b11, 6'h00, 1'b1, 16'h8000, 32'h0, 32'd1, 32'h0, 2'b00, 2'b00,
              5'd4, 4'b1000, 32'h0, 1'b0, 1'b1);
        check("ori_result", 128'(bus.out_result), 128'(32'h0000_8001));

        // beq taken with negative offset
        drive(1'b1, 2'b01, 6'h00, 1'b0, 16'hFFFF, 32'h100, 32'd3, 32'd3, 2'b00, 2'b00,
              5'd0, 4'b0001, 32'h0, 1'b0, 1'b1);
        check("beq_zero", 128'(bus.out_zero), 128'(1));
        check("beq_taken", 128'(bus.out_branch_taken), 128'(1));
        check("beq_target", 128'(bus.out_branch_target), 128'(32'h0000_00FC));

        // Backpressure: two stalled cycles, then the waiting entry loads
        repeat (2) begin
            drive(1'b1, 2'b10, 6'h20, 1'b0, 16'h0, 32'h0, 32'd9, 32'd9, 2'b00, 2'b00,
                  5'd1, 4'b1000, 32'h0, 1'b0, 1'b0);
            check("bp_valid", 128'(bus.out_valid), 128'(1));
            check("bp_hold", 128'(bus.out_branch_target), 128'(32'h0000_00FC));
        end
        drive(1'b1, 2'b10, 6'h20, 1'b0, 16'h0, 32'h0, 32'd9, 32'd9, 2'b00, 2'b00,
              5'd1, 4'b1000, 32'h0, 1'b0, 1'b1);
        check("bp_release", 128'(bus.out_result), 128'(32'd18));

        // Forward A from EX/MEM (18) plus 1
        drive(1'b1, 2'b10, 6'h20, 1'b0, 16'h0, 32'h0, 32'h99, 32'd1, 2'b01, 2'b00,
              5'd2, 4'b1000, 32'h0, 1'b0, 1'b1);
        check("fwd_result", 128'(bus.out_result), 128'(32'd19));

        // Illegal funct passes through with side effects stripped
        drive(1'b1, 2'b10, 6'h3F, 1'b0, 16'h0, 32'h0, 32'd4, 32'd5, 2'b00, 2'b00,
              5'd6, 4'b1110, 32'h0, 1'b0, 1'b1);
        check("ill_flag", 128'(bus.out_illegal), 128'(1));
        check("ill_ctrl", 128'({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}), 128'(0));

        // Flush with a same-cycle accept
        drive(1'b1, 2'b00, 6'h00, 1'b0, 16'h0, 32'h0, 32'd1, 32'd1, 2'b00, 2'b00,
              5'd1, 4'b1000, 32'h0, 1'b1, 1'b1);
        check("flush_valid", 128'(bus.out_valid), 128'(0));

        // Asynchronous reset while an entry is stalled
        drive(1'b1, 2'b00, 6'h00, 1'b0, 16'h0, 32'h0, 32'd7, 32'd8, 2'b00, 2'b00,
              5'd9, 4'b1000, 32'h0, 1'b0, 1'b0);
        check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_result", 128'(bus.out_result), 128'(0));
        sb_q.delete();
        m_result = 32'd0;
        m_valid  = 1'b0;
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_ctl = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 8))
                0: r_fn = 6'h20;  1: r_fn = 6'h21;  2: r_fn = 6'h22;
                3: r_fn = 6'h23;  4: r_fn = 6'h24;  5: r_fn = 6'h25;
                6: r_fn = 6'h27;  7: r_fn = 6'h2A;
                default: r_fn = 6'($urandom);
            endcase
            drive(($urandom_range(0, 3) != 0), r_ctl, r_fn, 1'($urandom), 16'($urandom),
                  $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom),
                  4'($urandom), $urandom, ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        repeat (3) idle();
        check("drain_empty", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
